// File: rtl/binary_countdown_4bit_synchronous_pkg.sv
// Shared definitions for the 4-bit synchronous countdown timer.
// State encodings and the default prescaler divisor are also used by the board top level.
package binary_countdown_4bit_synchronous_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // CLOCK_50 cycles per decrement tick (1 Hz on the board).
  localparam int unsigned TICK_DIV_DEFAULT = 50_000_000;

endpackage

// File: rtl/binary_countdown_4bit_synchronous_if.sv
// Control and status bundle of the countdown timer.
// The master drives load/start/hold/din; the slave (the timer) returns the count and status.
interface binary_countdown_4bit_synchronous_if #(
  parameter int unsigned WIDTH = 4
);
  logic             load;
  logic             start;
  logic             hold;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             tc;
  logic             done;
  logic             busy;

  modport master (
    output load, start, hold, din,
    input  q, qbar, tc, done, busy
  );

  modport slave (
    input  load, start, hold, din,
    output q, qbar, tc, done, busy
  );
endinterface

// File: rtl/binary_countdown_4bit_synchronous_tick_prescaler.sv
// Tick prescaler for the countdown timer: counts 0..TICK_DIV-1 while enabled,
// freezes while disabled, and issues a one-cycle tick on the last count.
module binary_countdown_4bit_synchronous_tick_prescaler
  import binary_countdown_4bit_synchronous_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned   CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] div_cnt;

  // A clear in the same cycle wins over a pending tick.
  assign tick = en && !clr && (div_cnt == LAST);

  // Divider count: clear has priority, otherwise advance and wrap while enabled.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (en) begin
      if (div_cnt == LAST) div_cnt <= '0;
      else                 div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/binary_countdown_4bit_synchronous.sv
// 4-bit synchronous countdown timer: parallel load, decrement once per prescaled
// tick, terminal-count flag and one-cycle done pulse.
// Optional macro BINARY_COUNTDOWN_AUTO_RELOAD_EN: reload din after the terminal
// tick and keep counting instead of stopping in DONE.
module binary_countdown_4bit_synchronous
  import binary_countdown_4bit_synchronous_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
  parameter int unsigned WIDTH    = 4
) (
  input  logic                                  CLOCK_50,
  input  logic                                  reset_n,
  binary_countdown_4bit_synchronous_if.slave    bus
);

  state_t           state;
  logic [WIDTH-1:0] q;
  logic             done;
  logic             tick;
  logic             clr;
  logic             en;
  logic             start_go;

  assign start_go = (state == IDLE) && bus.start && (q != '0);

`ifdef BINARY_COUNTDOWN_AUTO_RELOAD_EN
  // Set for the one cycle after the terminal tick, while q sits at 0 and done pulses.
  logic reload_pend;

  assign clr = bus.load || start_go || reload_pend;
  assign en  = (state == COUNT) && !bus.hold && !bus.load && !reload_pend;
`else
  assign clr = bus.load || start_go;
  assign en  = (state == COUNT) && !bus.hold && !bus.load;
`endif

  binary_countdown_4bit_synchronous_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .clr      (clr),
    .en       (en),
    .tick     (tick)
  );

  // Control FSM and count register; priority load > start > hold > tick.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      q     <= '0;
      done  <= 1'b0;
`ifdef BINARY_COUNTDOWN_AUTO_RELOAD_EN
      reload_pend <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef BINARY_COUNTDOWN_AUTO_RELOAD_EN
      reload_pend <= 1'b0;
`endif
      if (bus.load) begin
        q     <= bus.din;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              if (q != '0) begin
                state <= COUNT;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
          COUNT: begin
`ifdef BINARY_COUNTDOWN_AUTO_RELOAD_EN
            if (reload_pend) begin
              if (bus.din != '0) q     <= bus.din;
              else               state <= DONE;
            end else
`endif
            if (bus.hold) begin
              state <= PAUSE;
            end else if (tick) begin
              if (q > WIDTH'(1)) begin
                q <= q - WIDTH'(1);
              end else begin
                q    <= '0;
                done <= 1'b1;
`ifdef BINARY_COUNTDOWN_AUTO_RELOAD_EN
                reload_pend <= 1'b1;
`else
                state <= DONE;
`endif
              end
            end
          end
          PAUSE: begin
            if (!bus.hold) state <= COUNT;
          end
          DONE: begin
            state <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.q    = q;
  assign bus.qbar = ~q;
  assign bus.tc   = (q == '0);
  assign bus.done = done;
  assign bus.busy = (state == COUNT) || (state == PAUSE);

endmodule

// File: tb/tb_binary_countdown_4bit_synchronous.sv
// Directed self-checking bench for the countdown timer with TICK_DIV=4.
module tb_binary_countdown_4bit_synchronous;

  logic CLOCK_50;
  logic reset_n;
  int   tests;
  int   fails;

  binary_countdown_4bit_synchronous_if #(.WIDTH(4)) bus ();

  binary_countdown_4bit_synchronous #(
    .TICK_DIV (4),
    .WIDTH    (4)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic do_load(input logic [3:0] v);
    bus.din  = v;
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
  endtask

  task automatic do_start;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    tests++; if (bus.q !== 4'h0)    begin fails++; $display("FAIL por_q got %h exp 0", bus.q); end
    tests++; if (bus.qbar !== 4'hF) begin fails++; $display("FAIL por_qbar got %h exp F", bus.qbar); end
    tests++; if ({bus.tc, bus.done, bus.busy} !== 3'b100) begin fails++; $display("FAIL por_flags got %b exp 100", {bus.tc, bus.done, bus.busy}); end
    #10 reset_n = 1'b1;
    step(1);
  endtask

  task automatic test_countdown;
    do_load(4'd3);
    tests++; if (bus.q !== 4'd3 || bus.qbar !== 4'hC || bus.tc !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL cd_load q=%h qbar=%h tc=%b busy=%b exp 3 C 0 0", bus.q, bus.qbar, bus.tc, bus.busy); end
    do_start;
    tests++; if (bus.busy !== 1'b1 || bus.q !== 4'd3) begin fails++; $display("FAIL cd_start busy=%b q=%h exp 1 3", bus.busy, bus.q); end
    for (int k = 2; k >= 0; k--) begin
      step(3);
      tests++; if (bus.q !== 4'(k + 1) || bus.done !== 1'b0) begin fails++; $display("FAIL cd_hold_%0d q=%h done=%b exp %0d 0", k, bus.q, bus.done, k + 1); end
      step(1);
      tests++; if (bus.q !== 4'(k) || bus.done !== (k == 0)) begin fails++; $display("FAIL cd_dec_%0d q=%h done=%b exp %0d %0d", k, bus.q, bus.done, k, (k == 0)); end
    end
`ifdef BINARY_COUNTDOWN_AUTO_RELOAD_EN
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL cd_term_busy got %b exp 1", bus.busy); end
    do_load(4'd0);
`else
    tests++; if (bus.busy !== 1'b0 || bus.tc !== 1'b1) begin fails++; $display("FAIL cd_term busy=%b tc=%b exp 0 1", bus.busy, bus.tc); end
    step(1);
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL cd_done_width got %b exp 0", bus.done); end
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      tests++; if (bus.done !== 1'b0 || bus.q !== 4'd0) begin fails++; $display("FAIL cd_done_sticky done=%b q=%h exp 0 0", bus.done, bus.q); end
    end
    bus.start = 1'b0;
`endif
  endtask

  task automatic test_hold;
    do_load(4'd6);
    do_start;
    step(4);
    tests++; if (bus.q !== 4'd5) begin fails++; $display("FAIL hold_first q=%h exp 5", bus.q); end
    step(2);
    bus.hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      tests++; if (bus.q !== 4'd5 || bus.busy !== 1'b1) begin fails++; $display("FAIL hold_pause_%0d q=%h busy=%b exp 5 1", i, bus.q, bus.busy); end
    end
    bus.hold = 1'b0;
    step(2);
    tests++; if (bus.q !== 4'd5) begin fails++; $display("FAIL hold_resume_early q=%h exp 5", bus.q); end
    step(1);
    tests++; if (bus.q !== 4'd4) begin fails++; $display("FAIL hold_resume_dec q=%h exp 4", bus.q); end
    do_load(4'd0);
  endtask

  task automatic test_hold_tick;
    do_load(4'd4);
    do_start;
    step(8);
    tests++; if (bus.q !== 4'd2) begin fails++; $display("FAIL ht_pre q=%h exp 2", bus.q); end
    step(3);
    bus.hold = 1'b1;
    step(1);
    tests++; if (bus.q !== 4'd2 || bus.busy !== 1'b1) begin fails++; $display("FAIL ht_discard q=%h busy=%b exp 2 1", bus.q, bus.busy); end
    bus.hold = 1'b0;
    step(1);
    tests++; if (bus.q !== 4'd2) begin fails++; $display("FAIL ht_resume q=%h exp 2", bus.q); end
    step(1);
    tests++; if (bus.q !== 4'd1) begin fails++; $display("FAIL ht_dec q=%h exp 1", bus.q); end
    do_load(4'd0);
  endtask

  task automatic test_load_abort;
    do_load(4'd3);
    do_start;
    step(4);
    tests++; if (bus.q !== 4'd2) begin fails++; $display("FAIL la_pre q=%h exp 2", bus.q); end
    bus.din   = 4'd9;
    bus.load  = 1'b1;
    bus.start = 1'b1;
    step(1);
    bus.load  = 1'b0;
    bus.start = 1'b0;
    tests++; if (bus.q !== 4'd9 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL la_abort q=%h busy=%b done=%b exp 9 0 0", bus.q, bus.busy, bus.done); end
    for (int i = 0; i < 6; i++) begin
      step(1);
      tests++; if (bus.q !== 4'd9 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL la_idle_%0d q=%h busy=%b done=%b exp 9 0 0", i, bus.q, bus.busy, bus.done); end
    end
  endtask

  task automatic test_zero;
    do_load(4'd0);
    do_start;
    tests++; if (bus.done !== 1'b1 || bus.q !== 4'd0 || bus.busy !== 1'b0 || bus.tc !== 1'b1) begin fails++; $display("FAIL zero_start done=%b q=%h busy=%b tc=%b exp 1 0 0 1", bus.done, bus.q, bus.busy, bus.tc); end
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      tests++; if (bus.done !== 1'b0 || bus.q !== 4'd0) begin fails++; $display("FAIL zero_restart_%0d done=%b q=%h exp 0 0", i, bus.done, bus.q); end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_async_reset;
    do_load(4'd5);
    do_start;
    step(1);
    tests++; if (bus.q !== 4'd5 || bus.busy !== 1'b1) begin fails++; $display("FAIL ar_pre q=%h busy=%b exp 5 1", bus.q, bus.busy); end
    #3 reset_n = 1'b0;
    #1;
    tests++; if (bus.q !== 4'd0 || bus.qbar !== 4'hF) begin fails++; $display("FAIL ar_q q=%h qbar=%h exp 0 F", bus.q, bus.qbar); end
    tests++; if ({bus.tc, bus.done, bus.busy} !== 3'b100) begin fails++; $display("FAIL ar_flags got %b exp 100", {bus.tc, bus.done, bus.busy}); end
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    step(2);
    tests++; if (bus.q !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL ar_after q=%h busy=%b done=%b exp 0 0 0", bus.q, bus.busy, bus.done); end
  endtask

`ifdef BINARY_COUNTDOWN_AUTO_RELOAD_EN
  task automatic test_auto_reload;
    do_load(4'd2);
    do_start;
    for (int r = 0; r < 2; r++) begin
      step(4);
      tests++; if (bus.q !== 4'd1 || bus.busy !== 1'b1) begin fails++; $display("FAIL rl_one_%0d q=%h busy=%b exp 1 1", r, bus.q, bus.busy); end
      step(4);
      tests++; if (bus.q !== 4'd0 || bus.done !== 1'b1 || bus.busy !== 1'b1) begin fails++; $display("FAIL rl_zero_%0d q=%h done=%b busy=%b exp 0 1 1", r, bus.q, bus.done, bus.busy); end
      step(1);
      tests++; if (bus.q !== 4'd2 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin fails++; $display("FAIL rl_reload_%0d q=%h done=%b busy=%b exp 2 0 1", r, bus.q, bus.done, bus.busy); end
    end
    do_load(4'd0);
  endtask
`else
  task automatic test_no_wrap;
    do_load(4'd2);
    do_start;
    step(4);
    tests++; if (bus.q !== 4'd1) begin fails++; $display("FAIL nw_one q=%h exp 1", bus.q); end
    step(4);
    tests++; if (bus.q !== 4'd0 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin fails++; $display("FAIL nw_zero q=%h done=%b busy=%b exp 0 1 0", bus.q, bus.done, bus.busy); end
    for (int i = 0; i < 6; i++) begin
      step(1);
      tests++; if (bus.q !== 4'd0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL nw_stop_%0d q=%h done=%b busy=%b exp 0 0 0", i, bus.q, bus.done, bus.busy); end
    end
  endtask
`endif

  initial begin
    tests     = 0;
    fails     = 0;
    bus.load  = 1'b0;
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    bus.din   = 4'd0;
    test_reset;
    test_countdown;
    test_hold;
    test_hold_tick;
    test_load_abort;
    test_zero;
    test_async_reset;
`ifdef BINARY_COUNTDOWN_AUTO_RELOAD_EN
    test_auto_reload;
`else
    test_no_wrap;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
